// File: rtl/flop_en_rc_pkg.sv
// Shared constants for the enable/clear pipeline register family.
package flop_en_rc_pkg;

   localparam int FLOP_EN_RC_DEFAULT_WIDTH = 8;

endpackage : flop_en_rc_pkg

// File: rtl/flop_en_rc.sv
// Pipeline register: async reset, enable acts as stall, clear acts as flush.
// A flush only takes effect on an enabled edge, so a stalled stage keeps its contents.
module flop_en_rc
   import flop_en_rc_pkg::*;
#(
   parameter int WIDTH = FLOP_EN_RC_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (WIDTH < 1) begin : g_bad_width
      $error("flop_en_rc: WIDTH must be at least 1");
   end

   always_ff @(posedge clk, posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= clear ? '0 : d;
      end
   end

   // Reset is asynchronous, so q must already be zero at any edge seen with reset high.
   a_reset_zero : assert property (@(posedge clk) reset |-> (q == '0))
      else $error("flop_en_rc: q nonzero while reset asserted");

endmodule : flop_en_rc

// File: tb/tb_flop_en_rc.sv
// Self-checking bench for flop_en_rc: directed test-plan sequence, then randomized
// stall/flush/reset traffic checked every cycle against a rule-based expected value.
module tb_flop_en_rc;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             en = 1'b0;
   logic             clear = 1'b0;
   logic [WIDTH-1:0] d = '0;
   logic [WIDTH-1:0] q;

   logic [WIDTH-1:0] exp_q = '0;
   logic             cmp_on = 1'b0;
   int               errors = 0;
   int               checks = 0;

   flop_en_rc #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clear (clear),
      .d     (d),
      .q     (q)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: q=%h expected=%h at t=%0t", name, act, req, $time);
      end else begin
         $display("ok   %s: q=%h at t=%0t", name, act, $time);
      end
   endtask

   // Apply inputs shortly after a falling edge; expected value follows the priority rules.
   task automatic cycle(input logic r, input logic e, input logic c, input logic [WIDTH-1:0] dv);
      logic [WIDTH-1:0] exp_next;
      @(negedge clk);
      #1;
      reset = r;
      en    = e;
      clear = c;
      d     = dv;
      if (r) begin
         exp_q    = '0;
         exp_next = '0;
      end else if (e && c) begin
         exp_next = '0;
      end else if (e) begin
         exp_next = dv;
      end else begin
         exp_next = exp_q;
      end
      @(posedge clk);
      #1;
      exp_q = exp_next;
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (cmp_on) check("cycle", q, exp_q);
   end

   initial begin
      // Power-up reset held across two edges
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset_state", q, 8'h00);
      reset = 1'b0;
      cmp_on = 1'b1;

      // Async reset with clock idle low
      cycle(1'b0, 1'b1, 1'b0, 8'h5A);
      check("preload", q, 8'h5A);
      @(negedge clk);
      #1;
      d = 8'hA5;
      en = 1'b1;
      reset = 1'b1;
      exp_q = '0;
      #1;
      check("async_rst", q, 8'h00);
      reset = 1'b0;
      #1;
      check("rst_release_idle", q, 8'h00);
      en = 1'b0;
      d = 8'h3C;
      #1;
      check("hold_no_edge", q, 8'h00);

      // Enable hold, load, clear
      cycle(1'b0, 1'b0, 1'b0, 8'h3C);
      check("hold_edge", q, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h3C);
      check("load", q, 8'h3C);
      cycle(1'b0, 1'b1, 1'b1, 8'h3C);
      check("sync_clear", q, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h3C);
      check("hold_after_clear", q, 8'h00);

      // Clear ignored while stalled
      cycle(1'b0, 1'b1, 1'b0, 8'h3C);
      check("reload", q, 8'h3C);
      cycle(1'b0, 1'b0, 1'b1, 8'h55);
      check("clear_gated", q, 8'h3C);

      // Reset asserted while clk is high, then held across an enabled edge
      cycle(1'b0, 1'b1, 1'b0, 8'h3C);
      check("reload2", q, 8'h3C);
      reset = 1'b1;
      exp_q = '0;
      #1;
      check("rst_clk_high", q, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h77);
      check("rst_held_edge", q, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'hC3);
      check("first_load_after_rst", q, 8'hC3);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic r, e, c;
         r = ($urandom_range(0, 15) == 0);
         e = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 3) == 0);
         cycle(r, e, c, WIDTH'($urandom));
         if (!r && $urandom_range(0, 19) == 0) begin
            #1;
            reset = 1'b1;
            exp_q = '0;
            #1;
            check("mid_rst", q, 8'h00);
            reset = 1'b0;
         end
      end

      @(negedge clk);
      #1;
      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_flop_en_rc

// File: doc/flop_en_rc.md
# flop_en_rc

Parameterised D-register with write enable, asynchronous active-high reset and synchronous clear. It is the generic pipeline register of the CPU: `en` implements stall (hold), `clear` implements flush (bubble insertion), and `reset` forces a known zero state at power-up independent of the clock.

## Interface
Parameters:
- `WIDTH`, default 8, data width in bits (≥ 1).

Ports:
- `clk`  input  1  rising-edge clock; the block has one clock.
- `reset`  input  1  asynchronous, active-high reset; forces `q` to 0 immediately.
- `en`  input  1  write enable, active-high; qualifies both load and clear.
- `clear`  input  1  synchronous clear, active-high; loads 0 on the next enabled edge.
- `d`  input  WIDTH  data to load.
- `q`  output  WIDTH  registered data.

## Operation
- Priority, highest first: `reset` > (`en` && `clear`) > (`en` && !`clear`) > hold.
- `reset` = 1: `q` = 0 asynchronously, without waiting for a clock edge. `q` stays 0 while `reset` is held, whatever the other inputs are.
- Rising `clk` edge, `reset` = 0, `en` = 1, `clear` = 1: `q` ← 0.
- Rising `clk` edge, `reset` = 0, `en` = 1, `clear` = 0: `q` ← `d`.
- Rising `clk` edge, `reset` = 0, `en` = 0: `q` holds. `clear` is ignored while `en` = 0, so a stalled stage is never flushed.
- No other state. `q` is a direct register output with no combinational path from `d`, `en` or `clear`.

## Timing
- Reset value of `q`: all zeros.
- Reset assertion: `q` goes to 0 within the same delta/time step as the `reset` rising edge.
- Reset deassertion: `q` stays 0 until the first rising `clk` edge with `en` = 1, which loads `d` (or 0 if `clear` = 1).
- Load latency: 1 cycle. `d`, `en` and `clear` are sampled at the rising edge, and `q` updates after that edge.
- Between edges: changes on `d`, `en` or `clear` have no effect on `q`.
- Falling `clk` edges have no effect.
- Simultaneous `reset` and clock edge: `reset` wins and `q` = 0.
- `reset` asserted mid-cycle: clears `q` at once, and any pending load is lost.
- `clear` and `en` asserted in the same cycle: clear wins and `q` = 0.

## Structure
- Single module, one `always_ff @(posedge clk, posedge reset)` process. No sub-modules.
- No shared package content is required. The `WIDTH` parameter is the only configuration.
- Sibling register variants (plain flop, flop-with-reset, flop-with-enable) may reuse the same priority scheme but are separate blocks.
- RTL budget covers the register, parameter checks and simulation assertions:
  - `WIDTH` ≥ 1, checked at elaboration.
  - Optional assertion that `q` == 0 whenever `reset` is high.

## Test plan
- Async reset: `d` = 8'hA5, `en` = 1, `clk` idle low; raise `reset` → `q` = 8'h00 within 5 time units, with no clock edge. Lower `reset` and keep `clk` idle → `q` stays 8'h00.
- Enable hold: `en` = 0, `d` = 8'h3C, no edge → `q` = 8'h00. Give one rising edge with `en` = 0 → `q` = 8'h00.
- Load: `en` = 1, `d` = 8'h3C, one rising edge → `q` = 8'h3C one cycle later.
- Synchronous clear: from `q` = 8'h3C, set `clear` = 1 and `en` = 1, one rising edge → `q` = 8'h00.
  - Then `clear` = 0, `en` = 0, one edge → `q` stays 8'h00.
- Clear gated by enable: from `q` = 8'h3C, set `clear` = 1 and `en` = 0, one edge → `q` stays 8'h3C.
- Reload and reset priority: `en` = 1, `d` = 8'h3C, edge → `q` = 8'h3C.
  - Assert `reset` while `clk` is high with `en` = 1 → `q` = 8'h00 immediately.
  - Next edge with `reset` still high → `q` stays 8'h00.
